sram_stream_reader: RTL and testbench

- Downstream consumer of the 1728x99b activation/weight SRAM.
- On a start command it issues sequential reads over a programmable window (base, length) and absorbs the SRAM's 1-cycle read latency.
- It streams the 99-bit words to the compute stage over a valid/ready interface.
- A 2-entry output buffer guarantees no word is lost or duplicated under backpressure, while sustaining 1 word/cycle when the consumer is always ready.

---
 rtl/sram_stream_reader.sv | 123 ++++++++++++
 tb/tb_sram_stream_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_reader.sv
// Streams a (base, length) window of a read-only SRAM to a valid/ready consumer.
// A 2-entry buffer absorbs the SRAM's 1-cycle read latency without losing words under backpressure.
module sram_stream_reader #(
  parameter int DATA_W = 99,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 1728
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   accepted;
  logic              inflight;
  logic [1:0]        buf_count;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W-1:0] l);
    return ({1'b0, l} > DEPTH_C) ? DEPTH_C : {1'b0, l};
  endfunction

  // Words that will sit in the buffer after this edge; issuing only below 2 keeps pushes off a full buffer.
  assign pop        = out_valid & out_ready;
  assign occupancy  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == READ) && (occupancy < 3'd2);
  assign sram_csb   = ~issue;
  assign sram_wsb   = 1'b1;
  assign sram_raddr = addr;
  assign out_data   = buf0;
  assign out_valid  = (buf_count != 2'd0);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      issued    <= '0;
      accepted  <= '0;
      inflight  <= 1'b0;
      buf_count <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
    end else begin
      inflight <= issue;
      if (pop) accepted <= accepted + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            addr     <= base_addr;
            len      <= clamp_len(length);
            issued   <= '0;
            accepted <= '0;
            state    <= (length == '0) ? FIN : READ;
          end
        end
        READ: begin
          if (issue) begin
            addr   <= next_addr(addr);
            issued <= issued + 1'b1;
            if ((issued + 1'b1) == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && ((accepted + 1'b1) == len)) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // Read data lands one edge after its issue; buf0 is always the head.
      case ({inflight, pop})
        2'b10: begin
          if (buf_count == 2'd0) buf0 <= sram_rdata;
          else                   buf1 <= sram_rdata;
          buf_count <= buf_count + 1'b1;
        end
        2'b01: begin
          buf0      <= buf1;
          buf_count <= buf_count - 1'b1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf0 <= sram_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: table-driven jobs, hand-written reset/restart sequences, random jobs.
module tb_sram_stream_reader;
  localparam int DATA_W = 99;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1728;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              busy, done, sram_csb, sram_wsb;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;

  logic [DATA_W-1:0] mem [DEPTH];
  int errors = 0;
  int checks = 0;

  typedef struct {
    int b;
    int l;
    int mode;
    int exp_words;
    int exp_done;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  sram_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .sram_csb(sram_csb), .sram_wsb(sram_wsb),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // SRAM model: 1-cycle read latency.
  always @(posedge clk) if (!sram_csb) sram_rdata <= mem[int'(sram_raddr)];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_csb"}, sram_csb, 1'b1);
    check({tag, "_raddr"}, sram_raddr, 0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 0);
  endtask

  // mode 0: always ready, 1: repeating 1,0,0,1,0,1, 2: random ready
  task automatic run_job(input int b, input int l, input int mode, input int exp_words,
                         input int exp_done, input bit restart);
    int cyc = 0;
    int words = 0;
    int lows = 0;
    int first_v = 0;
    int done_cyc = 0;
    int last_hs = 0;
    int budget = 8 * exp_words + 30;
    bit [5:0] pat = 6'b101001;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [DATA_W-1:0] pd = '0;
    @(negedge clk);
    base_addr = ADDR_W'(b);
    length    = ADDR_W'(l);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (done_cyc == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (restart) begin
        if (cyc == 3) begin
          start = 1'b1; base_addr = 11'd7; length = 11'd3;
        end else begin
          start = 1'b0;
        end
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[(cyc - 1) % 6];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 1) check("busy_after_start", busy, 1'b1);
      if (pv && !pr) begin
        check("stall_valid_hold", out_valid, 1'b1);
        check("stall_data_hold", out_data, pd);
      end
      if (!sram_csb) begin
        check("raddr", sram_raddr, (b + lows) % DEPTH);
        lows++;
      end
      if (out_valid && first_v == 0) first_v = cyc;
      if (out_valid && out_ready) begin
        check("data", out_data, mem[(b + words) % DEPTH]);
        words++;
        last_hs = cyc;
      end
      if (!sram_csb) check("outstanding_le2", (lows - words) <= 2, 1'b1);
      if (done) done_cyc = cyc;
      pv = out_valid; pr = out_ready; pd = out_data;
    end
    check("done_seen", done_cyc != 0, 1'b1);
    check("words", words, exp_words);
    check("csb_low_cycles", lows, exp_words);
    if (exp_words > 0) begin
      check("first_valid_cycle", first_v, 3);
      check("done_after_last_hs", done_cyc, last_hs + 1);
    end else begin
      check("no_valid_empty_job", first_v, 0);
    end
    if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("idle_done", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_csb", sram_csb, 1'b1);
    end
  endtask

  task automatic reset_midjob();
    int hs = 0;
    int cyc = 0;
    @(negedge clk);
    base_addr = '0; length = 11'd10; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (hs < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) hs++;
    end
    check("midjob_handshakes", hs, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midjob_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_hold_done", done, 1'b0);
      check("rst_hold_valid", out_valid, 1'b0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_done", done, 1'b0);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_valid", out_valid, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
    vecs[0] = '{10,   5,    0, 5,    8};
    vecs[1] = '{1726, 4,    0, 4,    7};
    vecs[2] = '{0,    6,    1, 6,    -1};
    vecs[3] = '{5,    0,    0, 0,    1};
    vecs[4] = '{0,    2000, 0, 1728, 1731};

    #12;
    check_reset_outputs("reset");
    check("reset_wsb", sram_wsb, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 5; k++)
      run_job(vecs[k].b, vecs[k].l, vecs[k].mode, vecs[k].exp_words, vecs[k].exp_done, 1'b0);

    run_job(20, 8, 0, 8, 11, 1'b1);
    reset_midjob();
    run_job(0, 2, 0, 2, 5, 1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      mem[i] = r[DATA_W-1:0];
    end
    for (int j = 0; j < 12; j++) begin
      int b, l, m, ed;
      b  = (j % 3 == 0) ? int'($urandom_range(DEPTH - 8, DEPTH - 1)) : int'($urandom_range(0, DEPTH - 1));
      l  = int'($urandom_range(0, 40));
      m  = int'($urandom_range(0, 2));
      ed = (m == 0) ? ((l == 0) ? 1 : l + 3) : -1;
      run_job(b, l, m, l, ed, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
